// File: rtl/magma_engine.sv
// GOST R 34.12-2015 "Magma" 64-bit ECB engine with one block in flight.
// Runs ROUNDS_PER_CYCLE unrolled Feistel rounds per clock, uses a latched key and valid/ready handshakes.
module magma_engine #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int CNT_W            = 6
) (
    input  logic         clk,
    input  logic         reset_,
    input  logic         key_load,
    input  logic [255:0] key_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic         in_decrypt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic         busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // Packed pi0..pi7; entry v of a table sits in nibble (15 - v)
    localparam logic [7:0][63:0] PI = {
        64'h17ed05834fa69cb2, 64'h8e25691cf4b0da37,
        64'h5df692cab78143e0, 64'h7f5a816d093eb42c,
        64'hc821d4f670a53e9b, 64'hb3582fade174c960,
        64'h68239a5c1e47bd0f, 64'hc462a5b9e8d703f1
    };

    localparam logic [CNT_W-1:0] STEP = CNT_W'(ROUNDS_PER_CYCLE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(32 - ROUNDS_PER_CYCLE);

    function automatic logic [31:0] f_g(input logic [31:0] x);
        logic [31:0] s;
        s = '0;
        for (int n = 0; n < 8; n++) begin
            s[4*n +: 4] = PI[n][4*(15 - int'(x[4*n +: 4])) +: 4];
        end
        return {s[20:0], s[31:21]};
    endfunction

    state_t             r_state;
    state_t             w_state_next;
    logic               r_started;
    logic [255:0]       r_key;
    logic [31:0]        r_a1;
    logic [31:0]        r_a0;
    logic               r_dec;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;
    logic [63:0]        r_out_data;
    logic               w_accept;
    logic [31:0]        w_keys [8];
    logic [31:0]        w_a1 [ROUNDS_PER_CYCLE+1];
    logic [31:0]        w_a0 [ROUNDS_PER_CYCLE+1];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_key
            assign w_keys[gi] = r_key[255 - 32*gi -: 32];
        end
    endgenerate

    assign w_a1[0] = r_a1;
    assign w_a0[0] = r_a0;

    generate
        for (gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
            logic [CNT_W-1:0] w_rnd;
            logic             w_fwd;
            logic [2:0]       w_kidx;
            logic [31:0]      w_g;
            logic             w_last;
            assign w_rnd  = r_cnt + CNT_W'(gi);
            // Forward K1..K8 span: first 24 rounds encrypting, first 8 decrypting
            assign w_fwd  = r_dec ? (w_rnd < CNT_W'(8)) : (w_rnd < CNT_W'(24));
            assign w_kidx = w_fwd ? w_rnd[2:0] : ~w_rnd[2:0];
            assign w_g    = f_g(w_a0[gi] + w_keys[w_kidx]);
            assign w_last = (w_rnd == CNT_W'(31));
            assign w_a1[gi+1] = w_last ? (w_a1[gi] ^ w_g) : w_a0[gi];
            assign w_a0[gi+1] = w_last ? w_a0[gi] : (w_a1[gi] ^ w_g);
        end
    endgenerate

    assign w_accept = in_valid && r_started && (r_state == S_IDLE);

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = r_started;
                if (w_accept) w_state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == LAST) w_state_next = S_DONE;
            end
            S_DONE: begin
                busy = 1'b1;
                if (out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_started   <= 1'b0;
            r_key       <= '0;
            r_a1        <= '0;
            r_a0        <= '0;
            r_dec       <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_started <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (key_load) r_key <= key_in;
                    if (w_accept) begin
                        r_a1  <= in_data[63:32];
                        r_a0  <= in_data[31:0];
                        r_dec <= in_decrypt;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_a1  <= w_a1[ROUNDS_PER_CYCLE];
                    r_a0  <= w_a0[ROUNDS_PER_CYCLE];
                    r_cnt <= r_cnt + STEP;
                    if (r_cnt == LAST) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= {w_a1[ROUNDS_PER_CYCLE], w_a0[ROUNDS_PER_CYCLE]};
                    end
                end
                S_DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
